// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII transmit arbiter slice.
// Frame sizing constants, arbitration state encoding and the source selector
// type used by the arbiter and its beat gate.
package gmii_pkg;

    localparam int unsigned VID_BURST = 240;  // video words per frame
    localparam int unsigned AUD_BLK   = 32;   // audio words per ADE block
    localparam int unsigned IFG_CYC   = 12;   // idle cycles between frames
    localparam int unsigned AUD_MAX   = 2;    // audio grants in a row while video waits
    localparam int unsigned BURST_W   = 11;   // width of burst_len / beat counter

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        XFER,
        IFG
    } state_t;

    typedef enum logic {
        SRC_VID,
        SRC_AUD
    } src_t;

endpackage

// File: rtl/gmii_beat_gate.sv
// Read-enable gating for the granted send FIFO.
// Counts payload beats of the current frame, refuses reads past burst_len or
// from an empty FIFO, and flags rd_req hitting an empty granted FIFO.
// Ports:
//   tx_clk, sys_rst      clock, synchronous active-high reset
//   grant_vid/grant_aud  registered grants from the arbiter (never both set)
//   vid_empty/aud_empty  FIFO empty flags
//   rd_req               builder wants a payload word this cycle
//   pkt_done             frame finished; clears the beat counter
//   burst_len            payload words allowed in this frame
//   vid_rd_en/aud_rd_en  combinational FIFO read enables
//   underrun             registered 1-cycle pulse on a refused read to an empty FIFO
module gmii_beat_gate
    import gmii_pkg::*;
(
    input  logic               tx_clk,
    input  logic               sys_rst,
    input  logic               grant_vid,
    input  logic               grant_aud,
    input  logic               vid_empty,
    input  logic               aud_empty,
    input  logic               rd_req,
    input  logic               pkt_done,
    input  logic [BURST_W-1:0] burst_len,
    output logic               vid_rd_en,
    output logic               aud_rd_en,
    output logic               underrun
);

    logic [BURST_W-1:0] beats;
    src_t               src;
    logic               granted;
    logic               src_empty;
    logic               rd_ok;

    assign src       = grant_aud ? SRC_AUD : SRC_VID;
    assign granted   = grant_vid | grant_aud;
    assign src_empty = (src == SRC_AUD) ? aud_empty : vid_empty;
    // A request is eligible only while a grant is held and the burst has room.
    assign rd_ok     = rd_req & granted & (beats < burst_len);

    assign vid_rd_en = rd_ok & ~src_empty & (src == SRC_VID);
    assign aud_rd_en = rd_ok & ~src_empty & (src == SRC_AUD);

    always_ff @(posedge tx_clk) begin
        if (sys_rst) begin
            beats    <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= rd_ok & src_empty;
            if (pkt_done && granted) begin
                beats <= '0;
            end else if (vid_rd_en || aud_rd_en) begin
                beats <= beats + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Schedules the shared GMII transmit path between the video-line FIFO and the
// audio/aux FIFO, issues a start pulse plus word count per frame, gates FIFO
// reads to the frame burst and enforces the inter-frame gap.
// Ports:
//   tx_clk, sys_rst       125 MHz tx clock, synchronous active-high reset
//   vid_empty, vid_level  video FIFO empty flag and readable word count
//   aud_empty             audio FIFO empty flag
//   aud_req, aud_num      audio period closed pulse and its ADE block count
//   rd_req, pkt_done      builder word request and end-of-frame pulse
//   start                 1-cycle frame start pulse
//   grant_vid, grant_aud  owner of the current/next frame
//   burst_len             payload words of this frame
//   vid_rd_en, aud_rd_en  FIFO read enables (combinational)
//   underrun              rd_req hit an empty granted FIFO
//   aud_drop              pending audio request overwritten before service
module gmii_tx_arbiter
    import gmii_pkg::*;
(
    input  logic               tx_clk,
    input  logic               sys_rst,
    input  logic               vid_empty,
    input  logic [9:0]         vid_level,
    input  logic               aud_empty,
    input  logic               aud_req,
    input  logic [3:0]         aud_num,
    input  logic               rd_req,
    input  logic               pkt_done,
    output logic               start,
    output logic               grant_vid,
    output logic               grant_aud,
    output logic [BURST_W-1:0] burst_len,
    output logic               vid_rd_en,
    output logic               aud_rd_en,
    output logic               underrun,
    output logic               aud_drop
);

    state_t             state, state_nx;
    logic               vid_ok;
    logic               aud_new;
    logic               sel_aud, sel_vid;
    logic               aud_pend;
    logic [3:0]         aud_num_q;
    logic [1:0]         starv;
    logic [3:0]         ifg_cnt;
    logic               ifg_last;
    logic               start_nx, grant_vid_nx, grant_aud_nx;
    logic [BURST_W-1:0] burst_len_nx;

    assign vid_ok   = vid_level >= 10'(VID_BURST);
    assign aud_new  = aud_req && (aud_num != '0);
    assign ifg_last = ifg_cnt == 4'(IFG_CYC - 1);

    // Audio wins unless it has already been granted AUD_MAX times in a row
    // while a full video burst was waiting.
    always_comb begin
        sel_aud = 1'b0;
        sel_vid = 1'b0;
        if (state == ARB) begin
            if (aud_pend && ((starv < 2'(AUD_MAX)) || !vid_ok)) begin
                sel_aud = 1'b1;
            end else if (vid_ok) begin
                sel_vid = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = ARB;
            ARB:     if (sel_aud || sel_vid) state_nx = XFER;
            XFER:    if (pkt_done) state_nx = IFG;
            IFG:     if (ifg_last) state_nx = ARB;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start_nx     = sel_aud || sel_vid;
        grant_vid_nx = grant_vid;
        grant_aud_nx = grant_aud;
        burst_len_nx = burst_len;
        if (sel_vid) begin
            grant_vid_nx = 1'b1;
            grant_aud_nx = 1'b0;
            burst_len_nx = BURST_W'(VID_BURST);
        end else if (sel_aud) begin
            grant_vid_nx = 1'b0;
            grant_aud_nx = 1'b1;
            // Uses the count latched before any aud_req arriving this cycle.
            burst_len_nx = BURST_W'(aud_num_q) * BURST_W'(AUD_BLK);
        end else if ((state == XFER) && pkt_done) begin
            grant_vid_nx = 1'b0;
            grant_aud_nx = 1'b0;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            start     <= 1'b0;
            grant_vid <= 1'b0;
            grant_aud <= 1'b0;
            burst_len <= '0;
            aud_drop  <= 1'b0;
            aud_pend  <= 1'b0;
            aud_num_q <= '0;
            starv     <= '0;
            ifg_cnt   <= '0;
        end else begin
            state     <= state_nx;
            start     <= start_nx;
            grant_vid <= grant_vid_nx;
            grant_aud <= grant_aud_nx;
            burst_len <= burst_len_nx;
            ifg_cnt   <= ((state == IFG) && !ifg_last) ? ifg_cnt + 4'd1 : '0;
            // A request landing in the grant cycle re-arms pending, no drop.
            aud_drop  <= aud_new && aud_pend && !sel_aud;
            if (aud_new) begin
                aud_pend  <= 1'b1;
                aud_num_q <= aud_num;
            end else if (sel_aud) begin
                aud_pend  <= 1'b0;
            end
            if (sel_vid) begin
                starv <= '0;
            end else if (sel_aud && vid_ok && (starv < 2'(AUD_MAX))) begin
                starv <= starv + 2'd1;
            end
        end
    end

    gmii_beat_gate u_beat_gate (
        .tx_clk    (tx_clk),
        .sys_rst   (sys_rst),
        .grant_vid (grant_vid),
        .grant_aud (grant_aud),
        .vid_empty (vid_empty),
        .aud_empty (aud_empty),
        .rd_req    (rd_req),
        .pkt_done  (pkt_done),
        .burst_len (burst_len),
        .vid_rd_en (vid_rd_en),
        .aud_rd_en (aud_rd_en),
        .underrun  (underrun)
    );

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Self-checking bench for gmii_tx_arbiter: randomized levels, audio counts and
// rd_req gaps, checked against a rule-level model of the arbitration policy.
`timescale 1ns/1ps
module tb_gmii_tx_arbiter;

    localparam int VID_BURST = 240;
    localparam int AUD_BLK   = 32;
    localparam int IFG_CYC   = 12;
    localparam int AUD_MAX   = 2;

    logic        tx_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        vid_empty = 1'b0;
    logic [9:0]  vid_level = '0;
    logic        aud_empty = 1'b0;
    logic        aud_req = 1'b0;
    logic [3:0]  aud_num = '0;
    logic        rd_req = 1'b0;
    logic        pkt_done = 1'b0;
    logic        start, grant_vid, grant_aud;
    logic [10:0] burst_len;
    logic        vid_rd_en, aud_rd_en, underrun, aud_drop;

    int errors = 0;
    int checks = 0;
    int n_vrd, n_ard, n_und, n_drop, n_start;

    // Model of the arbitration policy: pending audio request, its block
    // count, and how many audio grants in a row were made over a ready video.
    bit m_pend;
    int m_num;
    int m_starv;

    gmii_tx_arbiter dut (
        .tx_clk    (tx_clk),
        .sys_rst   (sys_rst),
        .vid_empty (vid_empty),
        .vid_level (vid_level),
        .aud_empty (aud_empty),
        .aud_req   (aud_req),
        .aud_num   (aud_num),
        .rd_req    (rd_req),
        .pkt_done  (pkt_done),
        .start     (start),
        .grant_vid (grant_vid),
        .grant_aud (grant_aud),
        .burst_len (burst_len),
        .vid_rd_en (vid_rd_en),
        .aud_rd_en (aud_rd_en),
        .underrun  (underrun),
        .aud_drop  (aud_drop)
    );

    always #4 tx_clk = ~tx_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_req(int num);
        bit d = 1'b0;
        if (num != 0) begin
            d      = m_pend;
            m_pend = 1'b1;
            m_num  = num;
        end
        return d;
    endfunction

    // Returns 0 = nothing, 1 = video, 2 = audio; len = burst words.
    function automatic int m_arb(int vlevel, output int len);
        bit vok = (vlevel >= VID_BURST);
        if (m_pend && (m_starv < AUD_MAX || !vok)) begin
            len    = m_num * AUD_BLK;
            m_pend = 1'b0;
            if (vok) m_starv++;
            return 2;
        end
        if (vok) begin
            len     = VID_BURST;
            m_starv = 0;
            return 1;
        end
        len = 0;
        return 0;
    endfunction

    // Sample the cycle's outputs at negedge, then step to just after posedge.
    task automatic tick();
        @(negedge tx_clk);
        n_vrd   += int'(vid_rd_en);
        n_ard   += int'(aud_rd_en);
        n_und   += int'(underrun);
        n_drop  += int'(aud_drop);
        n_start += int'(start);
        @(posedge tx_clk);
        #1;
    endtask

    task automatic clr_cnt();
        n_vrd = 0; n_ard = 0; n_und = 0; n_drop = 0; n_start = 0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; vid_empty = 1'b0; aud_empty = 1'b0; aud_req = 1'b0;
        aud_num = '0; rd_req = 1'b0; pkt_done = 1'b0;
        repeat (3) tick();
        m_pend = 1'b0; m_num = 0; m_starv = 0;
        clr_cnt();
    endtask

    // Number of edges until start is seen high; -1 if the bound expires.
    task automatic wait_start(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (start === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic pulse_aud(input int num, output bit exp_drop);
        exp_drop = m_req(num);
        aud_req  = 1'b1;
        aud_num  = 4'(num);
        tick();
        aud_req  = 1'b0;
        aud_num  = '0;
    endtask

    // Random-gap reads until target words moved, then 20 more solid requests.
    task automatic run_reads(input int target);
        for (int c = 0; c < 1500; c++) begin
            rd_req = ($urandom_range(0, 3) != 0);
            tick();
            if (n_vrd + n_ard >= target) break;
        end
        rd_req = 1'b1;
        repeat (20) tick();
        rd_req = 1'b0;
    endtask

    task automatic end_frame();
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        sys_rst = 1'b1; rd_req = 1'b1; vid_level = 10'd240; aud_req = 1'b1; aud_num = 4'd3;
        repeat (3) tick();
        obs = {start, grant_vid, grant_aud, burst_len, vid_rd_en, aud_rd_en, underrun, aud_drop};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        aud_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_video_frame();
        int cyc, len, src;
        do_reset();
        vid_level = 10'($urandom_range(240, 1023));
        src = m_arb(int'(vid_level), len);
        sys_rst = 1'b0;
        wait_start(10, cyc);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL vid_start_cycle: got %0d expected 2", cyc); end
        checks++;
        if ({grant_aud, grant_vid} !== 2'(src)) begin
            errors++; $display("FAIL vid_grant: got %b expected %b", {grant_aud, grant_vid}, 2'(src));
        end
        checks++;
        if (int'(burst_len) != len) begin errors++; $display("FAIL vid_burst_len: got %0d expected %0d", burst_len, len); end
        clr_cnt();
        vid_level = '0;
        run_reads(len);
        checks++;
        if (n_vrd != len || n_ard != 0) begin
            errors++; $display("FAIL vid_read_count: got vid=%0d aud=%0d expected vid=%0d aud=0", n_vrd, n_ard, len);
        end
        checks++;
        if (n_start != 1) begin errors++; $display("FAIL vid_start_width: got %0d expected 1", n_start); end
        end_frame();
        checks++;
        if ({grant_aud, grant_vid} !== 2'b00) begin
            errors++; $display("FAIL vid_grant_drop: got %b expected 00", {grant_aud, grant_vid});
        end
    endtask

    task automatic test_audio_ifg();
        int cyc, len, src, num;
        bit d;
        do_reset();
        vid_level = 10'd239;
        sys_rst = 1'b0;
        wait_start(30, cyc);
        checks++;
        if (cyc != -1) begin errors++; $display("FAIL level_239_idle: got start at %0d expected none", cyc); end
        pulse_aud(3, d);
        src = m_arb(int'(vid_level), len);
        wait_start(5, cyc);
        checks++;
        if (cyc != 1 || {grant_aud, grant_vid} !== 2'(src)) begin
            errors++; $display("FAIL aud_grant: got cyc=%0d grant=%b expected cyc=1 grant=%b", cyc, {grant_aud, grant_vid}, 2'(src));
        end
        checks++;
        if (int'(burst_len) != len) begin errors++; $display("FAIL aud_burst_len: got %0d expected %0d", burst_len, len); end
        clr_cnt();
        run_reads(len);
        checks++;
        if (n_ard != len || n_vrd != 0) begin
            errors++; $display("FAIL aud_read_count: got aud=%0d vid=%0d expected aud=%0d vid=0", n_ard, n_vrd, len);
        end
        end_frame();
        // Audio request during IFG is still latched; its tick is one IFG edge.
        num = $urandom_range(1, 15);
        pulse_aud(num, d);
        src = m_arb(int'(vid_level), len);
        wait_start(40, cyc);
        checks++;
        if (cyc + 1 != IFG_CYC + 1) begin
            errors++; $display("FAIL ifg_gap: got %0d edges expected %0d", cyc + 1, IFG_CYC + 1);
        end
        checks++;
        if (int'(burst_len) != len || {grant_aud, grant_vid} !== 2'(src)) begin
            errors++; $display("FAIL ifg_aud_burst: got len=%0d grant=%b expected len=%0d grant=%b", burst_len, {grant_aud, grant_vid}, len, 2'(src));
        end
        vid_level = '0;
        end_frame();
    endtask

    task automatic test_starvation();
        int cyc, len, src, num;
        bit d;
        int order[6] = '{2, 2, 1, 2, 2, 1};
        do_reset();
        vid_level = 10'($urandom_range(240, 1023));
        num = $urandom_range(1, 15);
        d = m_req(num);
        sys_rst = 1'b0; aud_req = 1'b1; aud_num = 4'(num);
        tick();
        aud_req = 1'b0; aud_num = '0;
        for (int f = 0; f < 6; f++) begin
            src = m_arb(int'(vid_level), len);
            wait_start(40, cyc);
            checks++;
            if (cyc < 0 || {grant_aud, grant_vid} !== 2'(order[f])) begin
                errors++; $display("FAIL starv_order[%0d]: got cyc=%0d grant=%b expected grant=%b", f, cyc, {grant_aud, grant_vid}, 2'(order[f]));
            end
            checks++;
            if (int'(burst_len) != len || {grant_aud, grant_vid} !== 2'(src)) begin
                errors++; $display("FAIL starv_model[%0d]: got len=%0d grant=%b expected len=%0d grant=%b", f, burst_len, {grant_aud, grant_vid}, len, 2'(src));
            end
            if (!m_pend) pulse_aud($urandom_range(1, 15), d);
            // Short frame: a few reads then pkt_done well before burst end.
            repeat ($urandom_range(3, 10)) begin
                rd_req = $urandom_range(0, 1) != 0;
                tick();
            end
            rd_req = 1'b0;
            vid_level = 10'($urandom_range(240, 1023));
            end_frame();
        end
        vid_level = '0;
    endtask

    task automatic test_drop();
        int cyc, len, src, exp_drop;
        bit d;
        do_reset();
        vid_level = 10'($urandom_range(240, 1023));
        src = m_arb(int'(vid_level), len);
        sys_rst = 1'b0;
        wait_start(10, cyc);
        clr_cnt();
        exp_drop = 0;
        tick();
        pulse_aud(2, d); exp_drop += int'(d);
        tick();
        pulse_aud(5, d); exp_drop += int'(d);
        pulse_aud(0, d); exp_drop += int'(d);
        repeat (2) tick();
        checks++;
        if (n_drop != exp_drop || n_drop != 1) begin
            errors++; $display("FAIL aud_drop_count: got %0d expected %0d", n_drop, exp_drop);
        end
        vid_level = '0;
        end_frame();
        src = m_arb(int'(vid_level), len);
        wait_start(40, cyc);
        checks++;
        if (cyc != IFG_CYC + 1) begin errors++; $display("FAIL drop_ifg: got %0d expected %0d", cyc, IFG_CYC + 1); end
        checks++;
        if (int'(burst_len) != len || {grant_aud, grant_vid} !== 2'(src)) begin
            errors++; $display("FAIL drop_burst_len: got len=%0d grant=%b expected len=%0d grant=%b", burst_len, {grant_aud, grant_vid}, len, 2'(src));
        end
        end_frame();
    endtask

    task automatic test_underrun();
        int cyc, len, src;
        do_reset();
        vid_level = 10'd240;
        src = m_arb(int'(vid_level), len);
        sys_rst = 1'b0;
        wait_start(10, cyc);
        clr_cnt();
        vid_level = '0;
        rd_req = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (n_vrd >= 50) break;
        end
        vid_empty = 1'b1;
        repeat (10) tick();
        checks++;
        if (n_vrd != 50) begin errors++; $display("FAIL underrun_frozen: got %0d reads expected 50", n_vrd); end
        vid_empty = 1'b0;
        run_reads(len);
        checks++;
        if (n_vrd != len) begin errors++; $display("FAIL underrun_resume: got %0d reads expected %0d", n_vrd, len); end
        checks++;
        if (n_und != 10) begin errors++; $display("FAIL underrun_count: got %0d expected 10", n_und); end
        end_frame();
    endtask

    task automatic test_reset_mid();
        int cyc, len, src;
        logic [17:0] obs;
        do_reset();
        vid_level = 10'd240;
        sys_rst = 1'b0;
        wait_start(10, cyc);
        clr_cnt();
        rd_req = 1'b1;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (n_vrd >= 100) break;
        end
        sys_rst = 1'b1;
        tick();
        obs = {start, grant_vid, grant_aud, burst_len, vid_rd_en, aud_rd_en, underrun, aud_drop};
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL midframe_reset: got %h expected 0", obs); end
        rd_req = 1'b0;
        tick();
        m_pend = 1'b0; m_num = 0; m_starv = 0;
        src = m_arb(int'(vid_level), len);
        sys_rst = 1'b0;
        wait_start(10, cyc);
        checks++;
        if (cyc != 2 || {grant_aud, grant_vid} !== 2'(src)) begin
            errors++; $display("FAIL post_reset_start: got cyc=%0d grant=%b expected cyc=2 grant=%b", cyc, {grant_aud, grant_vid}, 2'(src));
        end
        clr_cnt();
        vid_level = '0;
        run_reads(len);
        checks++;
        if (n_vrd != len) begin errors++; $display("FAIL post_reset_reads: got %0d expected %0d", n_vrd, len); end
        end_frame();
    endtask

    initial begin
        clr_cnt();
        test_reset();
        test_video_frame();
        test_audio_ifg();
        test_starvation();
        test_drop();
        test_underrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
